// File: rtl/window_broadcast.sv
// window_broadcast: walks one command window (x fastest, then y, then
// channel) over a padded image, reads image RAM at 1-cycle latency and
// streams one pixel per cycle on a valid/ready port. Pixels that fall in the
// zero border are produced as 0 without touching the RAM.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cfg_dim, cfg_pad    unpadded image size and border width (static while busy)
//   cmd_*               window command (valid/ready, accepted only in IDLE)
//   rd_en, rd_addr      image RAM read port; rd_data returns one cycle later
//   out_*               pixel stream with padded coordinates and last flag
//   busy, done          command in progress / one-cycle completion pulse
module window_broadcast #(
    parameter int unsigned DIM_W  = 8,
    parameter int unsigned Z_W    = 9,
    parameter int unsigned DATA_W = 18,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned PAD_W  = 2,
    parameter int unsigned STEP_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIM_W-1:0]  cfg_dim,
    input  logic [PAD_W-1:0]  cfg_pad,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DIM_W-1:0]  cmd_x0,
    input  logic [DIM_W-1:0]  cmd_y0,
    input  logic [DIM_W-1:0]  cmd_w,
    input  logic [DIM_W-1:0]  cmd_h,
    input  logic [STEP_W-1:0] cmd_xstep,
    input  logic [STEP_W-1:0] cmd_ystep,
    input  logic [Z_W-1:0]    cmd_zlast,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DIM_W-1:0]  out_x,
    output logic [DIM_W-1:0]  out_y,
    output logic [Z_W-1:0]    out_z,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned EXT_W = DIM_W + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

    state_t state, state_nxt;

    // Latched command
    logic [DIM_W-1:0]  x0_q, y0_q, w_q, h_q;
    logic [STEP_W-1:0] xstep_q, ystep_q;
    logic [Z_W-1:0]    zlast_q;

    // Walk counters and running coordinates
    logic [DIM_W-1:0]  i_q, j_q, x_q, y_q;
    logic [Z_W-1:0]    z_q;

    // Address bases: row_base_q already includes the channel base
    logic [ADDR_W-1:0] chan_base_q, row_base_q, row0_q, row_step_q, chan_step_q;

    // Element issued last cycle, whose data is on rd_data now
    logic              pend_valid_q, pend_pad_q, pend_last_q;
    logic [DIM_W-1:0]  pend_x_q, pend_y_q;
    logic [Z_W-1:0]    pend_z_q;

    logic              advance, zero_cmd, start, issue, last_hs, done_set;
    logic              i_wrap, j_wrap, z_wrap, elem_last, cur_pad;
    logic [EXT_W-1:0]  pad_hi;
    logic [ADDR_W-1:0] row0_c, row_step_c, chan_step_c;

    // Per-command products built from shifted adds, evaluated once at accept
    function automatic logic [ADDR_W-1:0] shift_add(input logic [ADDR_W-1:0] a,
                                                    input logic [DIM_W-1:0]  b);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int k = 0; k < DIM_W; k++) begin
            if (b[k]) acc = acc + (a << k);
        end
        return acc;
    endfunction

    // y0 - pad is taken at address width so a negative start row wraps correctly
    assign row0_c      = shift_add(ADDR_W'(cmd_y0) - ADDR_W'(cfg_pad), cfg_dim);
    assign row_step_c  = shift_add(ADDR_W'(cfg_dim), DIM_W'(cmd_ystep));
    assign chan_step_c = shift_add(ADDR_W'(cfg_dim), cfg_dim);

    // Element classification
    always_comb begin
        advance   = !out_valid || out_ready;
        zero_cmd  = (cmd_w == '0) || (cmd_h == '0);
        i_wrap    = (i_q == w_q - DIM_W'(1));
        j_wrap    = (j_q == h_q - DIM_W'(1));
        z_wrap    = (z_q == zlast_q);
        elem_last = i_wrap && j_wrap && z_wrap;
        pad_hi    = EXT_W'(cfg_dim) + EXT_W'(cfg_pad);
        cur_pad   = (x_q < DIM_W'(cfg_pad)) || (y_q < DIM_W'(cfg_pad)) ||
                    (EXT_W'(x_q) >= pad_hi) || (EXT_W'(y_q) >= pad_hi);
        last_hs   = out_valid && out_ready && out_last;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid && !zero_cmd) state_nxt = RUN;
            RUN:     if (issue && elem_last)     state_nxt = FLUSH;
            FLUSH:   if (last_hs)                state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        cmd_ready = (state == IDLE) || rst;
        start     = (state == IDLE) && cmd_valid && !zero_cmd;
        issue     = !rst && (state == RUN) && advance;
        rd_en     = issue && !cur_pad;
        rd_addr   = row_base_q + ADDR_W'(x_q) - ADDR_W'(cfg_pad);
        done_set  = ((state == IDLE) && cmd_valid && zero_cmd) ||
                    ((state == FLUSH) && last_hs);
    end

    // Command latch, walk counters, issue stage and output register
    always_ff @(posedge clk) begin
        if (rst) begin
            x0_q <= '0; y0_q <= '0; w_q <= '0; h_q <= '0;
            xstep_q <= '0; ystep_q <= '0; zlast_q <= '0;
            i_q <= '0; j_q <= '0; z_q <= '0; x_q <= '0; y_q <= '0;
            chan_base_q <= '0; row_base_q <= '0; row0_q <= '0;
            row_step_q <= '0; chan_step_q <= '0;
            pend_valid_q <= 1'b0; pend_pad_q <= 1'b0; pend_last_q <= 1'b0;
            pend_x_q <= '0; pend_y_q <= '0; pend_z_q <= '0;
            out_valid <= 1'b0; out_last <= 1'b0;
            out_x <= '0; out_y <= '0; out_z <= '0; out_data <= '0;
            busy <= 1'b0; done <= 1'b0;
        end else begin
            if (start) begin
                x0_q <= cmd_x0; y0_q <= cmd_y0; w_q <= cmd_w; h_q <= cmd_h;
                xstep_q <= cmd_xstep; ystep_q <= cmd_ystep; zlast_q <= cmd_zlast;
                i_q <= '0; j_q <= '0; z_q <= '0;
                x_q <= cmd_x0; y_q <= cmd_y0;
                chan_base_q <= '0;
                row_base_q  <= row0_c;
                row0_q      <= row0_c;
                row_step_q  <= row_step_c;
                chan_step_q <= chan_step_c;
            end else if (issue && !elem_last) begin
                if (!i_wrap) begin
                    i_q <= i_q + DIM_W'(1);
                    x_q <= x_q + DIM_W'(xstep_q);
                end else begin
                    i_q <= '0;
                    x_q <= x0_q;
                    if (!j_wrap) begin
                        j_q        <= j_q + DIM_W'(1);
                        y_q        <= y_q + DIM_W'(ystep_q);
                        row_base_q <= row_base_q + row_step_q;
                    end else begin
                        j_q         <= '0;
                        y_q         <= y0_q;
                        z_q         <= z_q + Z_W'(1);
                        chan_base_q <= chan_base_q + chan_step_q;
                        row_base_q  <= chan_base_q + chan_step_q + row0_q;
                    end
                end
            end

            if (advance) begin
                pend_valid_q <= issue;
                out_valid    <= pend_valid_q;
                out_last     <= pend_valid_q && pend_last_q;
                if (pend_valid_q) begin
                    out_x    <= pend_x_q;
                    out_y    <= pend_y_q;
                    out_z    <= pend_z_q;
                    out_data <= pend_pad_q ? '0 : rd_data;
                end
            end

            if (issue) begin
                pend_x_q    <= x_q;
                pend_y_q    <= y_q;
                pend_z_q    <= z_q;
                pend_pad_q  <= cur_pad;
                pend_last_q <= elem_last;
            end

            busy <= (state_nxt != IDLE);
            done <= done_set;
        end
    end

endmodule
